morse_seq_module: RTL and testbench
===================================

MORSE_SEQ_MODULE -- requirements
Module: morse_seq_module

Interface
REQ-001 Parameter UNIT_CYCLES, default 12500000, clock cycles per Morse time unit (0.25 s at 50 MHz); legal range >= 1.
REQ-002 Parameter MAX_SYM, default 16, number of 2-bit symbol slots in msg_in; legal range 1..64.
REQ-003 CLK  input  1  system clock; all logic rising-edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 start_sig  input  1  level request to transmit; sampled only in IDLE.
REQ-006 msg_in  input  2*MAX_SYM  symbol list, slot i = msg_in[2i+1:2i], slot 0 sent first; 00 dot, 01 dash, 10 letter gap, 11 end.
REQ-007 rpt_in  input  4  message sent rpt_in+1 times.
REQ-008 busy  output  1  high while FSM is not IDLE.
REQ-009 done_sig  output  1  one-cycle completion pulse.
REQ-010 pin_out  output  1  registered key/buzzer drive, high = tone.

Function
REQ-011 FSM states: IDLE, FETCH, ON, OFF, WORD, DONE.
REQ-012 IDLE with start_sig=1 at edge k: latch msg_in and rpt_in, clear slot index and repeat counter, enter FETCH; later msg_in/rpt_in changes are ignored until next IDLE.
REQ-013 FETCH decodes the current slot in zero time: dot -> ON for 1 unit; dash -> ON for 3 units; letter gap -> OFF for 2 units; end, or slot index = MAX_SYM -> end-of-message handling.
REQ-014 Every ON element is followed by OFF for exactly 1 unit, so letter gap after an element totals 3 units low.
REQ-015 pin_out = 1 exactly during ON cycles, 0 otherwise; the first ON cycle is edge k+1 when slot 0 is a dot/dash.
REQ-016 Unit counter runs 0..n*UNIT_CYCLES-1 per element, n in {1,2,3,7}; width ceil(log2(7*UNIT_CYCLES)); no truncation.
REQ-017 End of message with repeat counter < latched rpt_in: enter WORD (pin_out 0 for 7 units), increment repeat counter, reset slot index to 0, re-enter FETCH.
REQ-018 End of message on final repetition: enter DONE; done_sig = 1 for exactly that cycle; next state IDLE.
REQ-019 Done timing: done_sig high at edge k+1+T*UNIT_CYCLES, T = total units of all elements, gaps and word gaps.
REQ-020 Slot 0 = end: no tone, done_sig at edge k+1; repeats of an empty message still insert WORD periods.
REQ-021 start_sig while busy is ignored; start_sig still high in IDLE after DONE restarts immediately (level-sensitive).
REQ-022 busy = 0 only in IDLE; busy is low in the cycle after the done_sig cycle.

Reset
REQ-023 RSTn low at any time, including mid-element: state IDLE, pin_out 0, done_sig 0, busy 0, all counters and latches 0, asynchronously.
REQ-024 After RSTn release, first start is accepted at the first rising edge with start_sig=1.

Configuration
REQ-025 Macro MORSE_ABORT_EN defined: add input abort_sig (1 bit); abort_sig=1 in any non-IDLE state forces DONE next edge, pin_out 0 that edge, done_sig pulses once; abort in IDLE has no effect.
REQ-026 Macro MORSE_ABORT_EN undefined: no abort_sig port; transmissions run to completion or reset.

Verification (UNIT_CYCLES=4, MAX_SYM=16)
REQ-027 SOS (dot,dot,dot,gap,dash,dash,dash,gap,dot,dot,dot,end), rpt_in=0, start at edge 0 -> pin_out highs of 4,4,4,12,12,12,4,4,4 cycles; done_sig at edge 113; busy low at 114.
REQ-028 Same message, rpt_in=1 -> two SOS frames separated by 28 low cycles after the trailing OFF; done_sig at edge 253.
REQ-029 slot0=end, rpt_in=0 -> pin_out never high; done_sig at edge 1.
REQ-030 All 16 slots dot, no end code -> 16 pulses of 4 cycles; done_sig at edge 129.
REQ-031 RSTn low at edge 10 of SOS -> pin_out 0 immediately; no done_sig; restart at edge 20 behaves as REQ-027 shifted by 20.
REQ-032 With MORSE_ABORT_EN, abort_sig at edge 30 of SOS -> pin_out 0 and done_sig at edge 31, IDLE at 32; msg_in change during busy has no effect.

Source files
------------

// File: rtl/morse_seq_module.sv
// ---------------------------------------------------------------------------
// morse_seq_module
//
// Purpose:
//   Plays a latched list of Morse symbols (dot, dash, letter gap, end) on a
//   single registered key/buzzer output.  A dot is 1 unit of tone and a dash
//   is 3 units.  Every tone is followed by 1 unit of silence.  A letter gap
//   adds 2 silent units.  Between repetitions there is a 7-unit word gap.
//   The whole message is sent rpt_in+1 times.  A one-cycle done_sig pulse
//   marks completion.
//
// Parameters:
//   UNIT_CYCLES : clock cycles per Morse time unit (>= 1)
//   MAX_SYM     : number of 2-bit symbol slots in msg_in (1..64)
//
// Ports:
//   CLK       in   system clock, rising edge
//   RSTn      in   asynchronous active-low reset
//   start_sig in   level request to transmit, sampled only while idle
//   msg_in    in   symbol list. Slot i = msg_in[2i+1:2i] and slot 0 is
//                  sent first. 00 dot, 01 dash, 10 letter gap, 11 end.
//   rpt_in    in   repeat count (message sent rpt_in+1 times)
//   abort_sig in   (only with MORSE_ABORT_EN) stop transmission and finish
//   busy      out  high whenever the sequencer is not idle
//   done_sig  out  one-cycle completion pulse
//   pin_out   out  registered tone drive, high = tone
//
// Build option:
//   MORSE_ABORT_EN : when defined, adds the abort_sig input.
// ---------------------------------------------------------------------------
module morse_seq_module #(
   parameter int unsigned UNIT_CYCLES = 12500000,
   parameter int unsigned MAX_SYM     = 16
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 start_sig,
   input  logic [2*MAX_SYM-1:0] msg_in,
   input  logic [3:0]           rpt_in,
`ifdef MORSE_ABORT_EN
   input  logic                 abort_sig,
`endif
   output logic                 busy,
   output logic                 done_sig,
   output logic                 pin_out
);

   // The counter must reach 7*UNIT_CYCLES-1 for the word gap.
   localparam int unsigned CW = $clog2(7 * UNIT_CYCLES) < 1 ? 1 : $clog2(7 * UNIT_CYCLES);
   // The slot index must be able to hold MAX_SYM itself. That value is
   // the "ran off the end" marker.
   localparam int unsigned SW = $clog2(MAX_SYM + 1);

   localparam logic [CW-1:0] LIM1 = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] LIM2 = CW'(2 * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] LIM3 = CW'(3 * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] LIM7 = CW'(7 * UNIT_CYCLES - 1);
   localparam logic [SW-1:0] SLOT_END = SW'(MAX_SYM);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ON    = 3'd2,
      OFF   = 3'd3,
      WORD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [CW-1:0]        lim_reg, lim_next;
   logic [SW-1:0]        slot_reg, slot_next;
   logic [3:0]           rpt_cnt_reg, rpt_cnt_next;
   logic [3:0]           rpt_reg, rpt_next;
   logic [2*MAX_SYM-1:0] msg_reg, msg_next;
   logic                 pin_reg, pin_next;
   logic                 done_reg, done_next;

   // ------------------------------------------------------------------
   // Slot decode. This is used both by FETCH and by the last cycle of
   // every silent period. That is why a new element starts directly
   // after the previous one, with no bubble cycle in between.
   // ------------------------------------------------------------------
   logic [2*MAX_SYM-1:0] sym_shift;
   logic [1:0]           sym;
   logic                 msg_end;

   state_t               dec_state;
   logic [CW-1:0]        dec_lim;
   logic                 dec_pin;
   logic [SW-1:0]        dec_slot;
   logic [3:0]           dec_rpt;

   assign sym_shift = msg_reg >> {slot_reg, 1'b0};
   assign sym       = sym_shift[1:0];
   assign msg_end   = (slot_reg == SLOT_END) || (sym == 2'b11);

   always_comb begin
      dec_state = DONE;
      dec_lim   = '0;
      dec_pin   = 1'b0;
      dec_slot  = slot_reg;
      dec_rpt   = rpt_cnt_reg;
      if (msg_end) begin
         if (rpt_cnt_reg < rpt_reg) begin
            // The slot index is rewound now, so the end of WORD decodes slot 0.
            dec_state = WORD;
            dec_lim   = LIM7;
            dec_slot  = '0;
            dec_rpt   = rpt_cnt_reg + 4'd1;
         end
      end else begin
         case (sym)
            2'b00: begin
               dec_state = ON;
               dec_lim   = LIM1;
               dec_pin   = 1'b1;
               dec_slot  = slot_reg + SW'(1);
            end
            2'b01: begin
               dec_state = ON;
               dec_lim   = LIM3;
               dec_pin   = 1'b1;
               dec_slot  = slot_reg + SW'(1);
            end
            default: begin
               dec_state = OFF;
               dec_lim   = LIM2;
               dec_slot  = slot_reg + SW'(1);
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      lim_next     = lim_reg;
      slot_next    = slot_reg;
      rpt_cnt_next = rpt_cnt_reg;
      rpt_next     = rpt_reg;
      msg_next     = msg_reg;
      pin_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_sig) begin
               state_next   = FETCH;
               msg_next     = msg_in;
               rpt_next     = rpt_in;
               slot_next    = '0;
               rpt_cnt_next = '0;
               cnt_next     = '0;
            end
         end
         FETCH: begin
            state_next   = dec_state;
            lim_next     = dec_lim;
            pin_next     = dec_pin;
            slot_next    = dec_slot;
            rpt_cnt_next = dec_rpt;
            cnt_next     = '0;
         end
         ON: begin
            pin_next = 1'b1;
            if (cnt_reg == lim_reg) begin
               // Every tone is followed by exactly one silent unit.
               state_next = OFF;
               lim_next   = LIM1;
               cnt_next   = '0;
               pin_next   = 1'b0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         OFF, WORD: begin
            if (cnt_reg == lim_reg) begin
               state_next   = dec_state;
               lim_next     = dec_lim;
               pin_next     = dec_pin;
               slot_next    = dec_slot;
               rpt_cnt_next = dec_rpt;
               cnt_next     = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

`ifdef MORSE_ABORT_EN
      // DONE is left out here, so an abort during the completion cycle
      // does not produce a second pulse.
      if (abort_sig && (state_reg != IDLE) && (state_reg != DONE)) begin
         state_next = DONE;
         pin_next   = 1'b0;
         cnt_next   = '0;
      end
`endif

      done_next = (state_next == DONE);
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         lim_reg     <= '0;
         slot_reg    <= '0;
         rpt_cnt_reg <= '0;
         rpt_reg     <= '0;
         msg_reg     <= '0;
         pin_reg     <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         lim_reg     <= lim_next;
         slot_reg    <= slot_next;
         rpt_cnt_reg <= rpt_cnt_next;
         rpt_reg     <= rpt_next;
         msg_reg     <= msg_next;
         pin_reg     <= pin_next;
         done_reg    <= done_next;
      end
   end

   assign busy     = (state_reg != IDLE);
   assign done_sig = done_reg;
   assign pin_out  = pin_reg;

endmodule

// File: tb/tb_morse_seq_module.sv
// ---------------------------------------------------------------------------
// tb_morse_seq_module
//
// Purpose:
//   Self-checking bench for morse_seq_module with UNIT_CYCLES=4, MAX_SYM=16.
//   A reference model expands the symbol list into the expected per-cycle
//   tone waveform. The bench then checks pin_out, busy and done_sig on
//   every cycle of each transmission.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_morse_seq_module;

   localparam int U = 4;
   localparam int NS = 16;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic          start_sig = 1'b0;
   logic [2*NS-1:0] msg_in = '0;
   logic [3:0]    rpt_in = '0;
`ifdef MORSE_ABORT_EN
   logic          abort_sig = 1'b0;
`endif
   logic          busy;
   logic          done_sig;
   logic          pin_out;

   int checks = 0;
   int errors = 0;

   morse_seq_module #(.UNIT_CYCLES(U), .MAX_SYM(NS)) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .start_sig (start_sig),
      .msg_in    (msg_in),
      .rpt_in    (rpt_in),
`ifdef MORSE_ABORT_EN
      .abort_sig (abort_sig),
`endif
      .busy      (busy),
      .done_sig  (done_sig),
      .pin_out   (pin_out)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: expand the symbols into an expected tone waveform,
   // one entry per clock cycle after the start edge.
   bit wave[$];
   task automatic build_wave(input logic [2*NS-1:0] msg, input logic [3:0] rpt);
      logic [1:0] s;
      wave.delete();
      for (int r = 0; r <= int'(rpt); r++) begin
         for (int i = 0; i < NS; i++) begin
            s = msg[2*i +: 2];
            if (s == 2'b11) break;
            if (s == 2'b00) begin
               repeat (U) wave.push_back(1'b1);
               repeat (U) wave.push_back(1'b0);
            end else if (s == 2'b01) begin
               repeat (3*U) wave.push_back(1'b1);
               repeat (U) wave.push_back(1'b0);
            end else begin
               repeat (2*U) wave.push_back(1'b0);
            end
         end
         if (r < int'(rpt)) repeat (7*U) wave.push_back(1'b0);
      end
   endtask

   function automatic logic [2*NS-1:0] pack(input logic [1:0] syms[NS]);
      logic [2*NS-1:0] m;
      for (int i = 0; i < NS; i++) m[2*i +: 2] = syms[i];
      return m;
   endfunction

   // Runs one transmission and checks every cycle up to and including the
   // first idle cycle. If hold is set, start_sig stays high throughout.
   task automatic run_msg(input string name, input logic [2*NS-1:0] msg,
                          input logic [3:0] rpt, input bit hold);
      int e0;
      e0 = errors;
      build_wave(msg, rpt);
      @(negedge CLK);
      msg_in = msg;
      rpt_in = rpt;
      start_sig = 1'b1;
      @(posedge CLK);
      #1;
      if (!hold) start_sig = 1'b0;
      // Later input changes must not affect the latched message.
      msg_in = $urandom;
      rpt_in = 4'($urandom_range(0, 15));
      for (int j = 0; j < wave.size(); j++) begin
         @(posedge CLK);
         #1;
         check({name, " pin"}, 32'(pin_out), 32'(wave[j]));
         check({name, " busy"}, 32'(busy), 32'd1);
         check({name, " done_early"}, 32'(done_sig), 32'd0);
      end
      @(posedge CLK);
      #1;
      check({name, " done"}, 32'(done_sig), 32'd1);
      check({name, " pin_at_done"}, 32'(pin_out), 32'd0);
      check({name, " busy_at_done"}, 32'(busy), 32'd1);
      @(posedge CLK);
      #1;
      check({name, " done_once"}, 32'(done_sig), 32'd0);
      check({name, " busy_after"}, 32'(busy), 32'd0);
      $display("txn %s rpt=%0d units=%0d done_edge=k+%0d errors=%0d", name, rpt,
               wave.size() / U, wave.size() + 1, errors - e0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTn = 1'b0;
      #1;
      check("rst pin", 32'(pin_out), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done_sig), 32'd0);
      repeat (3) @(negedge CLK);
      RSTn = 1'b1;
   endtask

   logic [1:0] syms[NS];
   logic [2*NS-1:0] sos, empty_msg, dots, rmsg;
   int r;

   initial begin
      // Build the SOS message.
      for (int i = 0; i < NS; i++) syms[i] = 2'b11;
      syms[0] = 2'b00; syms[1] = 2'b00; syms[2] = 2'b00; syms[3] = 2'b10;
      syms[4] = 2'b01; syms[5] = 2'b01; syms[6] = 2'b01; syms[7] = 2'b10;
      syms[8] = 2'b00; syms[9] = 2'b00; syms[10] = 2'b00; syms[11] = 2'b11;
      sos = pack(syms);
      empty_msg = {2*NS{1'b1}};
      dots = '0;

      // Check the reset state before any clock edge has an effect.
      #2;
      check("init pin", 32'(pin_out), 32'd0);
      check("init busy", 32'(busy), 32'd0);
      check("init done", 32'(done_sig), 32'd0);
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;

      run_msg("sos", sos, 4'd0, 1'b0);
      run_msg("sos_rpt1", sos, 4'd1, 1'b0);
      run_msg("empty", empty_msg, 4'd0, 1'b0);
      run_msg("empty_rpt2", empty_msg, 4'd2, 1'b0);
      run_msg("dots16", dots, 4'd0, 1'b0);

      // Reset in the middle of an element.
      @(negedge CLK);
      msg_in = sos; rpt_in = 4'd0; start_sig = 1'b1;
      @(posedge CLK);
      #1 start_sig = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      check("mid pin_high", 32'(pin_out), 32'd1);
      RSTn = 1'b0;
      #1;
      check("mid rst pin", 32'(pin_out), 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst done", 32'(done_sig), 32'd0);
      repeat (4) @(negedge CLK);
      RSTn = 1'b1;
      $display("txn mid_reset errors=%0d", errors);
      run_msg("sos_after_rst", sos, 4'd0, 1'b0);

      // Start held high: the transmission completes, then restarts from idle.
      run_msg("sos_hold", sos, 4'd0, 1'b1);
      @(posedge CLK);
      #1;
      check("hold restart busy", 32'(busy), 32'd1);
      start_sig = 1'b0;
      do_reset();

`ifdef MORSE_ABORT_EN
      @(negedge CLK);
      msg_in = sos; rpt_in = 4'd0; start_sig = 1'b1;
      @(posedge CLK);
      #1 start_sig = 1'b0;
      msg_in = '0;
      repeat (29) @(posedge CLK);
      #1 abort_sig = 1'b1;
      @(posedge CLK);
      #1;
      abort_sig = 1'b0;
      check("abort done", 32'(done_sig), 32'd1);
      check("abort pin", 32'(pin_out), 32'd0);
      @(posedge CLK);
      #1;
      check("abort idle", 32'(busy), 32'd0);
      check("abort done_once", 32'(done_sig), 32'd0);
      $display("txn abort errors=%0d", errors);
`endif

      // Randomized messages.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < NS; i++) begin
            r = $urandom_range(0, 19);
            syms[i] = (r < 8) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
         end
         rmsg = pack(syms);
         run_msg($sformatf("rand%0d", t), rmsg, 4'($urandom_range(0, 2)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
